// File: rtl/axi4_rd_responder_pkg.sv
// Shared constants and types for the AXI4 read responder slice.
// Optional feature macro: AXI_RD_RRESP_EN (adds the s_rresp port and SLVERR on out-of-range words).
package axi4_rd_responder_pkg;

    localparam int DEF_DATA_W    = 512;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_MEM_DEPTH = 1024;

    // Byte offset bits inside one 512-bit word.
    localparam int AXI_BYTE_SHIFT = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_rd_responder_if.sv
// AR/R channel bundle between a read master and the responder.
// Optional feature macro: AXI_RD_RRESP_EN (adds s_rresp).
interface axi4_rd_responder_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32
);
    logic              s_arvalid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic              s_arready;
    logic              s_rvalid;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rlast;
    logic              s_rready;
`ifdef AXI_RD_RRESP_EN
    logic [1:0]        s_rresp;

    modport master (
        output s_arvalid, s_araddr, s_arlen, s_rready,
        input  s_arready, s_rvalid, s_rdata, s_rlast, s_rresp
    );

    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rlast, s_rresp
    );
`else
    modport master (
        output s_arvalid, s_araddr, s_arlen, s_rready,
        input  s_arready, s_rvalid, s_rdata, s_rlast
    );

    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rlast
    );
`endif
endinterface

// File: rtl/axi4_rd_responder_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with enable and a
// registered, read-first output. The array itself is never reset so it maps
// onto block RAM; only the output register clears on reset.
module sdp_ram #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Preload/write port; a same-cycle read of this index still sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read output, updated only when a read is requested so data holds under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi4_rd_responder.sv
// AXI4 read-channel responder backed by an internal RAM with a preload port.
// Accepts one INCR burst at a time and streams arlen+1 beats with no bubbles.
// Optional feature macro: AXI_RD_RRESP_EN -- out-of-range word indices are
// not wrapped; those beats return zero data with SLVERR on s_rresp.
module axi4_rd_responder
    import axi4_rd_responder_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    axi4_rd_responder_if.slave bus,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int WORD_W = ADDR_W - AXI_BYTE_SHIFT;
`ifdef AXI_RD_RRESP_EN
    // Keep the full word index so out-of-range bursts can be flagged.
    localparam int CNT_W = WORD_W;
`else
    // Only the RAM index matters; upper address bits simply wrap away.
    localparam int CNT_W = IDX_W;
`endif

    rd_state_t         state;
    logic [CNT_W-1:0]  word;
    logic [7:0]        remaining;
    logic [CNT_W-1:0]  ar_word;
    logic [CNT_W-1:0]  next_word;
    logic              ar_fire;
    logic              r_fire;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] ram_q;
    logic              unused_addr_bits;

    assign ar_word   = bus.s_araddr[AXI_BYTE_SHIFT +: CNT_W];
    assign next_word = word + 1'b1;
    assign ar_fire   = (state == IDLE)  && bus.s_arvalid && bus.s_arready;
    assign r_fire    = (state == BURST) && bus.s_rvalid  && bus.s_rready;

    // A RAM read happens exactly on AR acceptance or on a non-final beat handshake,
    // so the next word lands in the output register for the following cycle.
    assign rd_en   = ar_fire || (r_fire && !bus.s_rlast);
    assign rd_addr = ar_fire ? ar_word[IDX_W-1:0] : next_word[IDX_W-1:0];

`ifdef AXI_RD_RRESP_EN
    assign unused_addr_bits = ^bus.s_araddr[AXI_BYTE_SHIFT-1:0];
`else
    assign unused_addr_bits = ^{bus.s_araddr[ADDR_W-1:AXI_BYTE_SHIFT+IDX_W],
                                bus.s_araddr[AXI_BYTE_SHIFT-1:0]};
`endif

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

`ifdef AXI_RD_RRESP_EN
    // Out-of-range beats present zero data alongside SLVERR.
    assign bus.s_rdata = (bus.s_rresp == RESP_SLVERR) ? '0 : ram_q;
`else
    assign bus.s_rdata = ram_q;
`endif

    // Burst FSM: accepts AR in IDLE, then walks the word counter one handshake at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            word          <= '0;
            remaining     <= '0;
            bus.s_arready <= 1'b0;
            bus.s_rvalid  <= 1'b0;
            bus.s_rlast   <= 1'b0;
`ifdef AXI_RD_RRESP_EN
            bus.s_rresp   <= RESP_OKAY;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.s_arready <= 1'b1;
                    if (ar_fire) begin
                        word          <= ar_word;
                        remaining     <= bus.s_arlen;
                        bus.s_arready <= 1'b0;
                        bus.s_rvalid  <= 1'b1;
                        bus.s_rlast   <= (bus.s_arlen == 8'd0);
`ifdef AXI_RD_RRESP_EN
                        bus.s_rresp   <= (|ar_word[CNT_W-1:IDX_W]) ? RESP_SLVERR : RESP_OKAY;
`endif
                        state         <= BURST;
                    end
                end
                BURST: begin
                    if (r_fire) begin
                        if (bus.s_rlast) begin
                            bus.s_rvalid  <= 1'b0;
                            bus.s_rlast   <= 1'b0;
                            bus.s_arready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            word        <= next_word;
                            remaining   <= remaining - 8'd1;
                            bus.s_rlast <= (remaining == 8'd1);
`ifdef AXI_RD_RRESP_EN
                            bus.s_rresp <= (|next_word[CNT_W-1:IDX_W]) ? RESP_SLVERR : RESP_OKAY;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
